// File: rtl/ahb_rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ahb_rr_grant_ctrl
// Brief  : Round-robin AHB grant scheduler that only re-grants at burst/lock boundaries.
// Rev    : 1.0
// ============================================================================
module ahb_rr_grant_ctrl #(
  parameter int MASTER_NUM     = 4,
  parameter int MASTER_W       = $clog2(MASTER_NUM),
  parameter int DEFAULT_MASTER = MASTER_NUM - 1,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] m_busreq,
  input  logic [MASTER_NUM-1:0] m_hlock,
  input  logic                  hready,
  input  logic [1:0]            s_htrans,
  input  logic [2:0]            s_hburst,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MASTER_W-1:0]   s_hmaster,
  output logic                  s_hmaster_lock
);

  localparam int CNT_W = 4;
  localparam int INC_W = $clog2(MAX_INCR_BEATS + 1);

  localparam logic [1:0]            c_trans_nonseq = 2'b10;
  localparam logic [1:0]            c_trans_seq    = 2'b11;
  localparam logic [2:0]            c_burst_single = 3'b000;
  localparam logic [2:0]            c_burst_incr   = 3'b001;
  localparam logic [MASTER_W-1:0]   c_default_idx  = MASTER_W'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] c_grant_one    = {{(MASTER_NUM-1){1'b0}}, 1'b1};
  localparam logic [INC_W-1:0]      c_incr_max     = INC_W'(MAX_INCR_BEATS);

  typedef enum logic [1:0] {
    ST_OWNED    = 2'd0,
    ST_HANDOVER = 2'd1,
    ST_BURST    = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  logic [MASTER_W-1:0]   grantee_q, grantee_d;
  logic [MASTER_W-1:0]   owner_q, owner_d;
  logic [MASTER_NUM-1:0] hgrant_q, hgrant_d;
  logic                  lock_q, lock_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INC_W-1:0]      incr_q, incr_d;

  logic [MASTER_W-1:0]   next_grantee;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  is_nonseq, is_seq, rearb;
  state_t                state;

  assign hgrant         = hgrant_q;
  assign s_hmaster      = owner_q;
  assign s_hmaster_lock = lock_q;

  assign is_nonseq = (s_htrans == c_trans_nonseq);
  assign is_seq    = (s_htrans == c_trans_seq);

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  always_comb begin
    case (s_hburst)
      3'b010, 3'b011: burst_cnt = CNT_W'(3);
      3'b100, 3'b101: burst_cnt = CNT_W'(7);
      3'b110, 3'b111: burst_cnt = CNT_W'(15);
      default:        burst_cnt = '0;
    endcase
  end

  // Grantee itself is scanned last so a lone requester can be re-granted.
  always_comb begin
    logic                found;
    logic [MASTER_W-1:0] idx;
    next_grantee = c_default_idx;
    found        = 1'b0;
    idx          = '0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      idx = MASTER_W'((int'(grantee_q) + i) % MASTER_NUM);
      if (!found && m_busreq[idx]) begin
        next_grantee = idx;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    grantee_d = grantee_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    incr_d    = incr_q;
    rearb     = 1'b0;
    state     = ST_OWNED;

    if (hready) begin
      owner_d = grantee_q;
      lock_d  = m_hlock[grantee_q];

      if (owner_q == grantee_q) begin
        if (is_nonseq)
          cnt_d = burst_cnt;
        else if (is_seq && cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
        if ((is_nonseq || is_seq) && s_hburst == c_burst_incr && incr_q != c_incr_max)
          incr_d = incr_q + 1'b1;
      end

      // Classification uses the post-beat count so the last burst beat is seen on time.
      if (owner_q != grantee_q)
        state = ST_HANDOVER;
      else if (lock_q || m_hlock[grantee_q])
        state = ST_LOCKED;
      else if (cnt_d != '0)
        state = ST_BURST;
      else
        state = ST_OWNED;

      case (state)
        ST_HANDOVER: rearb = 1'b0;
        ST_LOCKED:   rearb = !m_hlock[grantee_q] && (cnt_d <= CNT_W'(1));
        ST_BURST:    rearb = (cnt_d == CNT_W'(1));
        default:     rearb = !m_busreq[grantee_q]
                             || (is_nonseq && s_hburst == c_burst_single)
                             || (incr_d == c_incr_max);
      endcase

      if (rearb) begin
        grantee_d = next_grantee;
        cnt_d     = '0;
        incr_d    = '0;
      end
    end

    hgrant_d = c_grant_one << grantee_d;
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      grantee_q <= c_default_idx;
      owner_q   <= c_default_idx;
      hgrant_q  <= c_grant_one << DEFAULT_MASTER;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      incr_q    <= '0;
    end else begin
      grantee_q <= grantee_d;
      owner_q   <= owner_d;
      hgrant_q  <= hgrant_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      incr_q    <= incr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ahb_rr_grant_ctrl
// Brief  : Directed + random checks of ahb_rr_grant_ctrl against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_ahb_rr_grant_ctrl;

  localparam int N    = 4;
  localparam int DEF  = 3;
  localparam int MAXI = 16;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] m_busreq, m_hlock;
  logic       hready;
  logic [1:0] s_htrans;
  logic [2:0] s_hburst;
  logic [3:0] hgrant;
  logic [1:0] s_hmaster;
  logic       s_hmaster_lock;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  // Model state: grantee, owner, lock, fixed-burst beats left, INCR beats taken.
  int mg, mo, mrem, minc;
  bit mlk;

  // Stimulus generator state.
  int         g_rem, last_owner;
  logic [1:0] g_tr;
  logic [2:0] g_hb;
  logic       last_hr, hr;
  logic [3:0] br, lk_bits;

  logic [3:0] rr_exp [6];

  always #5 hclk = ~hclk;

  ahb_rr_grant_ctrl #(
    .MASTER_NUM(N), .DEFAULT_MASTER(DEF), .MAX_INCR_BEATS(MAXI)
  ) dut (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .hready(hready), .s_htrans(s_htrans), .s_hburst(s_hburst),
    .hgrant(hgrant), .s_hmaster(s_hmaster), .s_hmaster_lock(s_hmaster_lock)
  );

  function automatic int beats(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic bit bit_at(input logic [3:0] v, input int i);
    return v[i[1:0]];
  endfunction

  function automatic int pick(input int g, input logic [3:0] req);
    for (int k = 1; k <= N; k++) begin
      if (bit_at(req, (g + k) % N)) return (g + k) % N;
    end
    return DEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner follows grantee on each accepted cycle; the grant
  // moves only at a legal boundary, scanning round-robin from grantee+1.
  always @(posedge hclk or negedge hreset) begin
    int rem_n, inc_n, g_n;
    bit sw;
    if (!hreset) begin
      mg <= DEF; mo <= DEF; mlk <= 1'b0; mrem <= 0; minc <= 0;
    end else if (hready) begin
      rem_n = mrem; inc_n = minc; sw = 1'b0; g_n = mg;
      if (mo == mg) begin
        if (s_htrans == T_NSEQ)                 rem_n = beats(s_hburst) - 1;
        else if (s_htrans == T_SEQ && mrem > 0) rem_n = mrem - 1;
        if (s_htrans[1] && s_hburst == B_INCR && minc < MAXI) inc_n = minc + 1;
        if (mlk || bit_at(m_hlock, mg))
          sw = !bit_at(m_hlock, mg) && rem_n <= 1;
        else if (rem_n > 0)
          sw = (rem_n == 1);
        else
          sw = !bit_at(m_busreq, mg) || (s_htrans == T_NSEQ && s_hburst == B_SINGLE)
               || inc_n >= MAXI;
      end
      if (sw) begin
        g_n = pick(mg, m_busreq); rem_n = 0; inc_n = 0;
      end
      mlk  <= bit_at(m_hlock, mg);
      mo   <= mg;
      mg   <= g_n;
      mrem <= rem_n;
      minc <= inc_n;
    end
  end

  always @(negedge hclk) begin
    if (cmp_en) begin
      chk("model_hgrant", {28'b0, hgrant}, 32'(1 << mg));
      chk("model_s_hmaster", {30'b0, s_hmaster}, mo);
      chk("model_s_hmaster_lock", {31'b0, s_hmaster_lock}, {31'b0, mlk});
    end
  end

  task automatic drive(input logic [3:0] b, input logic [3:0] l, input logic r,
                       input logic [1:0] tr, input logic [2:0] hb);
    m_busreq = b; m_hlock = l; hready = r; s_htrans = tr; s_hburst = hb;
    @(negedge hclk);
  endtask

  task automatic rst_pulse();
    hreset = 1'b0;
    drive(4'b0, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b0, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    hreset = 1'b1;
  endtask

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
    rst_pulse();
    chk("reset_hgrant", {28'b0, hgrant}, 32'h8);
    chk("reset_s_hmaster", {30'b0, s_hmaster}, 32'd3);
    chk("reset_lock", {31'b0, s_hmaster_lock}, 32'd0);
    cmp_en = 1;

    // Three requesters, SINGLE transfers: one switch per transfer.
    for (int e = 1; e <= 12; e++) begin
      drive(4'b0111, 4'b0, 1'b1, T_NSEQ, B_SINGLE);
      if (e % 2 == 1) chk("rr_single_grant", {28'b0, hgrant}, {28'b0, rr_exp[(e-1)/2]});
    end

    // M0 INCR4 with M1 waiting: grant moves on the 3rd beat, owner after the 4th.
    rst_pulse();
    drive(4'b0001, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b0011, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    chk("incr4_owner_m0", {30'b0, s_hmaster}, 32'd0);
    drive(4'b0011, 4'b0, 1'b1, T_NSEQ, B_INCR4);
    drive(4'b0011, 4'b0, 1'b1, T_SEQ, B_INCR4);
    chk("incr4_hold_beat2", {28'b0, hgrant}, 32'h1);
    drive(4'b0011, 4'b0, 1'b1, T_SEQ, B_INCR4);
    chk("incr4_grant_beat3", {28'b0, hgrant}, 32'h2);
    chk("incr4_owner_beat3", {30'b0, s_hmaster}, 32'd0);
    drive(4'b0011, 4'b0, 1'b1, T_SEQ, B_INCR4);
    chk("incr4_owner_beat4", {30'b0, s_hmaster}, 32'd1);

    // M2 INCR8 stalled three cycles on beat 5.
    rst_pulse();
    drive(4'b0100, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b0101, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b0101, 4'b0, 1'b1, T_NSEQ, B_INCR8);
    for (int i = 0; i < 3; i++) drive(4'b0101, 4'b0, 1'b1, T_SEQ, B_INCR8);
    for (int i = 0; i < 3; i++) drive(4'b0101, 4'b0, 1'b0, T_SEQ, B_INCR8);
    chk("incr8_stall_grant", {28'b0, hgrant}, 32'h4);
    chk("incr8_stall_owner", {30'b0, s_hmaster}, 32'd2);
    drive(4'b0101, 4'b0, 1'b1, T_SEQ, B_INCR8);
    drive(4'b0101, 4'b0, 1'b1, T_SEQ, B_INCR8);
    chk("incr8_hold_beat6", {28'b0, hgrant}, 32'h4);
    drive(4'b0101, 4'b0, 1'b1, T_SEQ, B_INCR8);
    chk("incr8_grant_beat7", {28'b0, hgrant}, 32'h1);
    chk("incr8_owner_beat7", {30'b0, s_hmaster}, 32'd2);
    drive(4'b0101, 4'b0, 1'b1, T_SEQ, B_INCR8);
    chk("incr8_owner_beat8", {30'b0, s_hmaster}, 32'd0);

    // M1 locked across SINGLEs with M0 requesting.
    rst_pulse();
    drive(4'b0010, 4'b0010, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b0011, 4'b0010, 1'b1, T_IDLE, B_SINGLE);
    chk("lock_owner", {30'b0, s_hmaster}, 32'd1);
    chk("lock_flag_on", {31'b0, s_hmaster_lock}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 4'b0010, 1'b1, T_NSEQ, B_SINGLE);
      chk("lock_hold_grant", {28'b0, hgrant}, 32'h2);
      chk("lock_hold_flag", {31'b0, s_hmaster_lock}, 32'd1);
    end
    drive(4'b0011, 4'b0000, 1'b1, T_IDLE, B_SINGLE);
    chk("lock_release_grant", {28'b0, hgrant}, 32'h1);
    chk("lock_release_flag", {31'b0, s_hmaster_lock}, 32'd0);

    // M0 undefined-length INCR loses tenure after 16 accepted beats.
    rst_pulse();
    drive(4'b0001, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b1001, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    drive(4'b1001, 4'b0, 1'b1, T_NSEQ, B_INCR);
    for (int i = 0; i < 14; i++) drive(4'b1001, 4'b0, 1'b1, T_SEQ, B_INCR);
    chk("incr_hold_beat15", {28'b0, hgrant}, 32'h1);
    drive(4'b1001, 4'b0, 1'b1, T_SEQ, B_INCR);
    chk("incr_switch_beat16", {28'b0, hgrant}, 32'h8);

    // Asynchronous reset asserted mid-cycle.
    drive(4'b1001, 4'b0, 1'b1, T_IDLE, B_SINGLE);
    @(posedge hclk);
    #2 hreset = 1'b0;
    #1;
    chk("async_rst_hgrant", {28'b0, hgrant}, 32'h8);
    chk("async_rst_owner", {30'b0, s_hmaster}, 32'd3);
    chk("async_rst_lock", {31'b0, s_hmaster_lock}, 32'd0);
    @(negedge hclk);
    hreset = 1'b1;

    // Randomised traffic, checked every cycle against the model.
    g_rem = 0; g_tr = T_IDLE; g_hb = B_SINGLE; last_hr = 1'b1; last_owner = DEF;
    br = 4'b0111; lk_bits = 4'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 1000 == 999) begin
        #2 hreset = 1'b0;
        @(negedge hclk);
        hreset = 1'b1;
        g_rem = 0; g_tr = T_IDLE; last_owner = DEF; last_hr = 1'b1;
      end
      if (c % 8 == 0)  br = 4'($urandom_range(15));
      if (c % 32 == 0) lk_bits = ($urandom_range(3) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0;
      if (last_hr || mo != last_owner) begin
        if (g_rem > 0 && mo == last_owner) begin
          g_tr = ($urandom_range(7) == 0) ? T_BUSY : T_SEQ;
          if (g_tr == T_SEQ) g_rem--;
        end else begin
          g_rem = 0;
          if ($urandom_range(3) == 0) g_tr = T_IDLE;
          else begin
            g_tr  = T_NSEQ;
            g_hb  = 3'($urandom_range(7));
            g_rem = (g_hb == B_INCR) ? int'($urandom_range(22)) : beats(g_hb) - 1;
          end
        end
      end
      last_owner = mo;
      hr = ($urandom_range(4) != 0);
      drive(br, lk_bits, hr, g_tr, g_hb);
      last_hr = hr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
